// File: rtl/module_bcd_adder.sv
// Digit-serial BCD adder: latches two NDIG-digit packed BCD operands on start,
// adds one digit per clock and presents a registered NDIG+1 digit sum with an error flag.
module module_bcd_adder #(
  parameter int NDIG = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NDIG-1:0]       first_num,
  input  logic [4*NDIG-1:0]       second_num,
  input  logic                    start,
  output logic                    busy,
  output logic                    valid,
  output logic                    err,
  output logic [4*(NDIG+1)-1:0]   sum,
  output logic [1:0]              dbg_state
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is sampled only in IDLE; busy is high while digits are
  // being added; valid pulses for one cycle when sum/err take a new value.
  state_t state, state_nxt;

  logic [4*NDIG-1:0]     op_a, op_b;
  logic [4*(NDIG+1)-1:0] acc;
  logic                  carry;
  logic                  err_acc;
  logic [IW-1:0]         idx;

  logic [3:0] dig_a, dig_b, dig_out;
  logic [4:0] dig_sum;
  logic       dig_carry;
  logic       last_dig;

  assign dig_a     = op_a[4*idx +: 4];
  assign dig_b     = op_b[4*idx +: 4];
  assign dig_sum   = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, carry};
  assign dig_carry = (dig_sum > 5'd9);
  // Decimal correction: adding 6 skips the six unused codes of the nibble.
  assign dig_out   = dig_carry ? (dig_sum[3:0] + 4'd6) : dig_sum[3:0];
  assign last_dig  = (idx == IW'(NDIG - 1));

  assign busy      = (state == ADD);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last_dig) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      err_acc <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      err     <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a    <= first_num;
            op_b    <= second_num;
            acc     <= '0;
            carry   <= 1'b0;
            err_acc <= 1'b0;
            idx     <= '0;
          end
        end
        ADD: begin
          acc[4*idx +: 4] <= dig_out;
          carry           <= dig_carry;
          err_acc         <= err_acc | (dig_a > 4'd9) | (dig_b > 4'd9);
          if (last_dig) begin
            acc[4*NDIG +: 4] <= {3'b000, dig_carry};
            idx              <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          sum   <= err_acc ? '0 : acc;
          err   <= err_acc;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_module_bcd_adder.sv
// Bench for module_bcd_adder: directed and random operand pairs, expected results
// queued at launch and compared when valid pulses.
module tb_module_bcd_adder;

  localparam int NDIG = 3;
  localparam int W    = 4 * NDIG;
  localparam int SW   = 4 * (NDIG + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  first_num, second_num;
  logic          start;
  logic          busy, valid, err;
  logic [SW-1:0] sum;
  logic [1:0]    dbg_state;

  module_bcd_adder #(.NDIG(NDIG)) dut (
    .clk        (clk),
    .rst        (rst),
    .first_num  (first_num),
    .second_num (second_num),
    .start      (start),
    .busy       (busy),
    .valid      (valid),
    .err        (err),
    .sum        (sum),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [SW-1:0] exp_q[$];
  logic          exp_err_q[$];
  int            exp_cyc_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [SW-1:0] int_to_bcd(input int v);
    logic [SW-1:0] r = '0;
    int x = v;
    for (int i = 0; i < NDIG + 1; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    logic b = 1'b0;
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input int start_cyc);
    logic bad;
    bad = has_bad(a) | has_bad(b);
    exp_q.push_back(bad ? '0 : int_to_bcd(bcd_to_int(a) + bcd_to_int(b)));
    exp_err_q.push_back(bad);
    exp_cyc_q.push_back(start_cyc + NDIG + 1);
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(valid), 32'd0);
      end else begin
        check("sum", 32'(sum), 32'(exp_q.pop_front()));
        check("err", 32'(err), 32'(exp_err_q.pop_front()));
        check("latency_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic push);
    @(negedge clk);
    first_num  = a;
    second_num = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) push_exp(a, b, cyc);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
      exp_err_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  logic [W-1:0] ra, rb;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    first_num  = '0;
    second_num = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // basic add with busy profile
    launch(12'h123, 12'h456, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_profile", 32'(busy), (i < NDIG) ? 32'd1 : 32'd0);
    end
    wait_done();

    launch(12'h999, 12'h999, 1'b1); wait_done();
    launch(12'h001, 12'h999, 1'b1); wait_done();
    launch(12'h000, 12'h000, 1'b1); wait_done();
    launch(12'h500, 12'h000, 1'b1); wait_done();

    // invalid digit, then recovery
    launch(12'h0A5, 12'h111, 1'b1); wait_done();
    launch(12'h111, 12'h111, 1'b1); wait_done();

    // start during ADD and during DONE is ignored
    launch(12'h321, 12'h123, 1'b1);
    @(negedge clk);
    first_num  = 12'h777;
    second_num = 12'h777;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);
    check("ignored_start_busy", 32'(busy), 32'd0);

    // operand change mid-ADD
    launch(12'h234, 12'h345, 1'b1);
    @(negedge clk);
    first_num  = 12'h999;
    second_num = 12'h999;
    wait_done();

    // start held high: back-to-back launches every NDIG+2 cycles
    @(negedge clk);
    first_num  = 12'h468;
    second_num = 12'h357;
    start      = 1'b1;
    @(posedge clk);
    #1 push_exp(first_num, second_num, cyc);
    repeat (NDIG + 2) @(posedge clk);
    #1 push_exp(first_num, second_num, cyc);
    start = 1'b0;
    wait_done();

    // reset during ADD aborts the operation
    launch(12'h456, 12'h456, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    check("abort_no_valid", 32'(valid), 32'd0);
    launch(12'h250, 12'h250, 1'b1); wait_done();

    // random operands with occasional invalid digits
    repeat (12) begin
      for (int i = 0; i < NDIG; i++) begin
        ra[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      launch(ra, rb, 1'b1);
      wait_done();
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/module_bcd_adder.md
Name: module_bcd_adder

Overview:
- Downstream arithmetic stage for the DIP-switch number-entry block. Consumes the two captured 3-digit BCD operands (first_num, second_num) and adds them digit-serially, one BCD digit per clock.
- Produces a 4-digit BCD sum for the 7-segment display driver, with a start/busy/valid handshake.
- Flags any operand digit greater than 9 as an error.

Parameters:
- NDIG, 3, number of BCD digits per operand; operand width 4*NDIG bits, result width 4*(NDIG+1) bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- first_num  in  4*NDIG  operand A, packed BCD; bits [3:0] are the units digit
- second_num  in  4*NDIG  operand B, packed BCD; bits [3:0] are the units digit
- start  in  1  request: latch the operands and begin the addition
- busy  out  1  high while an addition is in progress
- valid  out  1  one-cycle pulse: sum and err are updated this cycle
- err  out  1  invalid BCD digit detected in the last operation
- sum  out  4*(NDIG+1)  packed BCD result; the top digit is the carry (0 or 1)

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, valid=0, err=0, sum=0; internal operand, carry and index registers cleared. Reset takes priority over every other input.
- States:
  - IDLE: busy=0, valid=0. When start=1 at an edge:
    - latch first_num into opA and second_num into opB;
    - carry=0, idx=0, errAcc=0;
    - go to ADD.
  - ADD: busy=1. Each edge processes digit idx:
    - t = opA[idx] + opB[idx] + carry, 5-bit arithmetic;
    - if t>9: digit=(t+6) mod 16, carry=1; else digit=t, carry=0;
    - store digit into accumulator digit idx;
    - errAcc |= (opA[idx]>9) | (opB[idx]>9);
    - idx++. After digit NDIG-1 is processed, write the final carry to accumulator digit NDIG and go to DONE.
  - DONE: busy=0. On entry, sum, err and valid are registered:
    - sum = errAcc ? 0 : accumulator; err = errAcc;
    - valid=1 for exactly this one cycle; go to IDLE on the next edge.
- Latency: start is sampled at edge k; valid=1 in the cycle following edge k+NDIG+1; busy=1 for NDIG cycles.
- sum and err hold their values between operations. They change only in DONE or on reset.
- Operands are latched at start. Changes on first_num/second_num during ADD have no effect on the result.
- start while busy=1, or in the DONE cycle: ignored. It is not queued.
- start=1 held continuously: a new operation launches from each IDLE visit, giving back-to-back additions every NDIG+2 cycles.
- Maximum result for NDIG=3: 999+999=1998, fits in 4 digits; no overflow is possible.
- Invalid digits (10..15): processing still runs the full NDIG cycles so latency is constant; the result is forced to 0 with err=1.
- rst during ADD: operation aborted, no valid pulse, outputs take reset values; the next start behaves normally.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- After reset, start with first_num=12'h123, second_num=12'h456 -> exactly 4 cycles later valid=1 for 1 cycle; sum=16'h0579, err=0; busy high for 3 cycles.
- Carry chain: 12'h999 + 12'h999 -> sum=16'h1998, err=0; and 12'h001 + 12'h999 -> sum=16'h1000.
- Zero and identity: 12'h000 + 12'h000 -> sum=16'h0000; 12'h500 + 12'h000 -> sum=16'h0500.
- Invalid BCD: first_num=12'h0A5, second_num=12'h111 -> valid pulses at normal latency with sum=16'h0000, err=1. A following valid 12'h111 + 12'h111 -> sum=16'h0222, err=0.
- Handshake:
  - pulse start again while busy with different operands -> ignored; only the first result appears, with one valid pulse;
  - change first_num mid-ADD -> result unaffected.
- Reset mid-operation: assert rst one cycle after start (during ADD) -> no valid pulse, sum=0, busy=0, err=0. A subsequent 12'h250 + 12'h250 -> sum=16'h0500.
